// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a borrow flop
// process A - B LSB first, with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sb, res;
   logic [CW-1:0]    cnt;
   logic             br, a_msb, b_msb;
   logic             d, br_nxt, last;

   // Full-subtractor cell on the current operand LSBs.
   assign d      = sa[0] ^ sb[0] ^ br;
   assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign last   = (cnt == CW'(WIDTH - 1));

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = SHIFT;
         SHIFT:   if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // NOTE: every datapath register is reset, so a reset mid-operation leaves
   // no stale operand or result bits behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sa    <= a;
                  sb    <= b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
               end
            end
            SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               res <= {d, res[WIDTH-1:1]};
               br  <= br_nxt;
               if (last) begin
                  diff   <= {d, res[WIDTH-1:1]};
                  borrow <= br_nxt;
                  // Signed overflow: operand signs differ and the result sign differs from A.
                  ovf    <= (a_msb != b_msb) & (d != a_msb);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor at WIDTH=8: arithmetic corner cases,
// latency, backpressure, input-ignore during SHIFT and mid-operation reset.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       borrow, ovf, busy;

   int n_tests = 0;
   int n_fail  = 0;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present operands at a negedge and let the following posedge accept them.
   task automatic accept(input logic [7:0] av, input logic [7:0] bv, input bit hold_valid);
      @(negedge clk);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!hold_valid) in_valid = 1'b0;
   endtask

   // Count edges until out_valid, scrambling a/b each cycle when asked; bounded.
   task automatic wait_done(input string tag, input bit scramble, output int edges);
      edges = 0;
      while (!out_valid && edges < 20) begin
         if (scramble) begin
            a = 8'($urandom);
            b = 8'($urandom);
         end
         @(posedge clk);
         #1;
         edges++;
      end
      in_valid = 1'b0;
      check({tag, " latency"}, 32'(edges), 32'd8);
   endtask

   task automatic check_result(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " diff"},      32'(diff),      32'(ed));
      check({tag, " borrow"},    32'(borrow),    32'(eb));
      check({tag, " ovf"},       32'(ovf),       32'(eo));
      check({tag, " busy"},      32'(busy),      32'd1);
   endtask

   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo);
      int edges;
      accept(av, bv, 1'b0);
      check({tag, " in_ready low"}, 32'(in_ready), 32'd0);
      wait_done(tag, 1'b0, edges);
      check_result(tag, ed, eb, eo);
      @(posedge clk);
      #1;
      check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
      check({tag, " idle in_ready"},  32'(in_ready),  32'd1);
      check({tag, " idle diff kept"}, 32'(diff),      32'(ed));
   endtask

   initial begin
      int edges;
      int seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      #12;
      check("rst in_ready",  32'(in_ready),  32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst diff",      32'(diff),      32'd0);
      check("rst borrow",    32'(borrow),    32'd0);
      check("rst ovf",       32'(ovf),       32'd0);
      check("rst busy",      32'(busy),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("5A-3C", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
      run_op("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      run_op("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
      run_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_op("A5-A5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);

      // Backpressure: result held while out_ready is low.
      out_ready = 1'b0;
      accept(8'hC8, 8'h64, 1'b0);
      wait_done("bp", 1'b0, edges);
      for (int i = 0; i < 5; i++) begin
         check_result("bp hold", 8'h64, 1'b0, 1'b1);
         check("bp hold in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp release out_valid", 32'(out_valid), 32'd0);
      check("bp release in_ready",  32'(in_ready),  32'd1);
      run_op("FF-7F", 8'hFF, 8'h7F, 8'h80, 1'b0, 1'b0);

      // in_valid held and operands changing during SHIFT must be ignored.
      accept(8'h33, 8'h44, 1'b1);
      check("ign in_ready", 32'(in_ready), 32'd0);
      wait_done("ign", 1'b1, edges);
      check_result("ign", 8'hEF, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("ign idle in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("ign no reaccept", 32'(in_ready), 32'd1);

      // Reset pulsed during SHIFT discards the operation.
      accept(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst in_ready",  32'(in_ready),  32'd1);
      check("mrst out_valid", 32'(out_valid), 32'd0);
      check("mrst diff",      32'(diff),      32'd0);
      check("mrst borrow",    32'(borrow),    32'd0);
      check("mrst ovf",       32'(ovf),       32'd0);
      check("mrst busy",      32'(busy),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1;
      end
      check("mrst no out_valid", 32'(seen), 32'd0);
      run_op("10-20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
